// File: rtl/pooling_unit_2x2_if.sv
// Pooling unit bus interface.
// Bundles the start/done handshake, the read port to the input feature-map
// RAM and the write port to the output feature-map buffer.
//   start, mode_avg, relu_en  : transaction request and its options
//   busy, done                : transaction status
//   in_map_rd_en/addr/pixel   : input RAM read port (1-cycle read latency)
//   out_map_write_en/addr/pixel : output buffer write port
// The slave modport is the pooling unit; the master modport is the controller
// and memory side that drives it.
interface pooling_unit_2x2_if #(
   parameter int DATA_W     = 16,
   parameter int IN_ADDR_W  = 10,
   parameter int OUT_ADDR_W = 8
);
   logic                         start;
   logic                         mode_avg;
   logic                         relu_en;
   logic                         busy;
   logic                         done;
   logic                         in_map_rd_en;
   logic        [IN_ADDR_W-1:0]  in_map_addr;
   logic signed [DATA_W-1:0]     in_map_pixel;
   logic                         out_map_write_en;
   logic        [OUT_ADDR_W-1:0] out_map_addr;
   logic signed [DATA_W-1:0]     out_map_pixel;

   modport slave (
      input  start, mode_avg, relu_en, in_map_pixel,
      output busy, done, in_map_rd_en, in_map_addr,
             out_map_write_en, out_map_addr, out_map_pixel
   );

   modport master (
      output start, mode_avg, relu_en, in_map_pixel,
      input  busy, done, in_map_rd_en, in_map_addr,
             out_map_write_en, out_map_addr, out_map_pixel
   );
endinterface

// File: rtl/pooling_unit_2x2.sv
// 2x2 stride-2 pooling engine for multi-channel feature maps.
// One start/done transaction pools every channel: for each output pixel it
// reads the four window elements from the input RAM, reduces them by max or
// floor-average, optionally clamps negatives to zero, and writes the result.
// Each output costs six cycles (4 fetch, 1 drain, 1 write).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any transaction
//   bus     : handshake, input-RAM read port and output write port
module pooling_unit_2x2 #(
   parameter int DATA_W     = 16,
   parameter int IN_W       = 26,
   parameter int IN_H       = 26,
   parameter int CHANNELS   = 1,
   parameter int IN_ADDR_W  = 10,
   parameter int OUT_ADDR_W = 8
) (
   input logic               clk,
   input logic               reset_n,
   pooling_unit_2x2_if.slave bus
);
   localparam int OUT_W  = IN_W / 2;
   localparam int OUT_H  = IN_H / 2;
   localparam int N      = OUT_W * OUT_H * CHANNELS;
   localparam int OCOL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int OROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

   state_t                  state;
   logic [1:0]              k;
   logic [OCOL_W-1:0]       ocol, nxt_ocol;
   logic [OROW_W-1:0]       orow, nxt_orow;
   logic [CH_W-1:0]         ch, nxt_ch;
   logic [OUT_ADDR_W-1:0]   out_idx;
   logic                    avg_q, relu_q;
   logic signed [DATA_W-1:0]   pix, max_acc, max_fin, result;
   logic signed [DATA_W+1:0]   sum_acc, sum_fin;

   function automatic logic signed [DATA_W+1:0] sext(input logic signed [DATA_W-1:0] x);
      return (DATA_W+2)'(x);
   endfunction

   // Tie keeps the earlier element.
   function automatic logic signed [DATA_W-1:0] max2(input logic signed [DATA_W-1:0] keep,
                                                      input logic signed [DATA_W-1:0] cand);
      return (cand > keep) ? cand : keep;
   endfunction

   // Arithmetic shift floors toward -inf; the mean of four DATA_W values always fits DATA_W.
   function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [DATA_W+1:0] sum);
      logic signed [DATA_W+1:0] s;
      s = sum >>> 2;
      return s[DATA_W-1:0];
   endfunction

   function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] x,
                                                            input logic en);
      return (en && x < 0) ? '0 : x;
   endfunction

   // Window element e: bit 1 selects the lower row, bit 0 the right column.
   function automatic logic [IN_ADDR_W-1:0] elem_addr(input logic [CH_W-1:0] c,
                                                       input logic [OROW_W-1:0] r,
                                                       input logic [OCOL_W-1:0] q,
                                                       input logic [1:0] e);
      int a;
      a = int'(c) * IN_W * IN_H + (2 * int'(r) + int'(e[1])) * IN_W + 2 * int'(q) + int'(e[0]);
      return IN_ADDR_W'(a);
   endfunction

   always_comb begin
      pix     = bus.in_map_pixel;
      max_fin = max2(max_acc, pix);
      sum_fin = sum_acc + sext(pix);
      result  = relu_clamp(avg_q ? avg_floor(sum_fin) : max_fin, relu_q);

      nxt_ocol = ocol + 1'b1;
      nxt_orow = orow;
      nxt_ch   = ch;
      if (ocol == OCOL_W'(OUT_W - 1)) begin
         nxt_ocol = '0;
         nxt_orow = orow + 1'b1;
         if (orow == OROW_W'(OUT_H - 1)) begin
            nxt_orow = '0;
            nxt_ch   = ch + 1'b1;
         end
      end
   end

   // Window reduction: element 0 seeds the accumulators, later elements fold in.
   always_ff @(posedge clk) begin
      if (state == FETCH && k != 2'd0) begin
         if (k == 2'd1) begin
            max_acc <= pix;
            sum_acc <= sext(pix);
         end else begin
            max_acc <= max_fin;
            sum_acc <= sum_fin;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                <= IDLE;
         k                    <= '0;
         ocol                 <= '0;
         orow                 <= '0;
         ch                   <= '0;
         out_idx              <= '0;
         avg_q                <= 1'b0;
         relu_q               <= 1'b0;
         bus.in_map_rd_en     <= 1'b0;
         bus.in_map_addr      <= '0;
         bus.out_map_write_en <= 1'b0;
         bus.out_map_addr     <= '0;
         bus.out_map_pixel    <= '0;
         bus.busy             <= 1'b0;
         bus.done             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  avg_q            <= bus.mode_avg;
                  relu_q           <= bus.relu_en;
                  k                <= '0;
                  ocol             <= '0;
                  orow             <= '0;
                  ch               <= '0;
                  out_idx          <= '0;
                  bus.in_map_rd_en <= 1'b1;
                  bus.in_map_addr  <= '0;
                  bus.busy         <= 1'b1;
                  state            <= FETCH;
               end
            end
            FETCH: begin
               if (k == 2'd3) begin
                  bus.in_map_rd_en <= 1'b0;
                  state            <= DRAIN;
               end else begin
                  bus.in_map_addr <= elem_addr(ch, orow, ocol, k + 2'd1);
                  k               <= k + 2'd1;
               end
            end
            DRAIN: begin
               bus.out_map_write_en <= 1'b1;
               bus.out_map_addr     <= out_idx;
               bus.out_map_pixel    <= result;
               state                <= WRITE;
            end
            WRITE: begin
               bus.out_map_write_en <= 1'b0;
               if (out_idx == OUT_ADDR_W'(N - 1)) begin
                  bus.done <= 1'b1;
                  state    <= DONE;
               end else begin
                  out_idx          <= out_idx + 1'b1;
                  ocol             <= nxt_ocol;
                  orow             <= nxt_orow;
                  ch               <= nxt_ch;
                  k                <= '0;
                  bus.in_map_rd_en <= 1'b1;
                  bus.in_map_addr  <= elem_addr(nxt_ch, nxt_orow, nxt_ocol, 2'd0);
                  state            <= FETCH;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pooling_unit_2x2.sv
// Testbench for pooling_unit_2x2: a 4x4 single-channel instance and a 5x5
// two-channel instance, each with a 1-cycle-latency input RAM model and an
// output capture monitor.
module tb_pooling_unit_2x2;
   logic clk = 1'b0;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pooling_unit_2x2_if #(.DATA_W(16), .IN_ADDR_W(10), .OUT_ADDR_W(8)) ifa ();
   pooling_unit_2x2_if #(.DATA_W(16), .IN_ADDR_W(10), .OUT_ADDR_W(8)) ifb ();

   pooling_unit_2x2 #(.DATA_W(16), .IN_W(4), .IN_H(4), .CHANNELS(1),
                      .IN_ADDR_W(10), .OUT_ADDR_W(8))
      dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.slave));

   pooling_unit_2x2 #(.DATA_W(16), .IN_W(5), .IN_H(5), .CHANNELS(2),
                      .IN_ADDR_W(10), .OUT_ADDR_W(8))
      dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.slave));

   logic signed [15:0] mem_a [1024];
   logic signed [15:0] mem_b [1024];

   always @(posedge clk) if (ifa.in_map_rd_en) ifa.in_map_pixel <= mem_a[ifa.in_map_addr];
   always @(posedge clk) if (ifb.in_map_rd_en) ifb.in_map_pixel <= mem_b[ifb.in_map_addr];

   logic signed [15:0] out_a [4];
   logic signed [15:0] out_b [8];
   int   nwr_a = 0, ndone_a = 0, st_a = 0, done_rel_a = 0, dbl_a = 0;
   int   nwr_b = 0, ndone_b = 0, st_b = 0, done_rel_b = 0, bad_b = 0;
   int   wr_rel_a [64];
   logic prev_we_a = 1'b0;

   always @(posedge clk) begin
      if (ifa.start && !ifa.busy) st_a <= cyc;
      if (ifa.out_map_write_en) begin
         out_a[ifa.out_map_addr[1:0]] <= ifa.out_map_pixel;
         wr_rel_a[nwr_a[5:0]]         <= cyc - st_a;
         nwr_a                        <= nwr_a + 1;
      end
      if (ifa.done) begin
         ndone_a    <= ndone_a + 1;
         done_rel_a <= cyc - st_a;
      end
      if (ifa.out_map_write_en && prev_we_a) dbl_a <= dbl_a + 1;
      prev_we_a <= ifa.out_map_write_en;
   end

   always @(posedge clk) begin
      if (ifb.start && !ifb.busy) st_b <= cyc;
      if (ifb.out_map_write_en) begin
         out_b[ifb.out_map_addr[2:0]] <= ifb.out_map_pixel;
         nwr_b                        <= nwr_b + 1;
      end
      if (ifb.done) begin
         ndone_b    <= ndone_b + 1;
         done_rel_b <= cyc - st_b;
      end
      if (ifb.in_map_rd_en && ((((ifb.in_map_addr % 25) / 5) == 4) ||
                               ((ifb.in_map_addr % 5) == 4) || (ifb.in_map_addr >= 50)))
         bad_b <= bad_b + 1;
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_a(input logic m, input logic r);
      @(negedge clk);
      ifa.start = 1'b1; ifa.mode_avg = m; ifa.relu_en = r;
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   task automatic wait_a(input int base);
      int n = 0;
      while (ndone_a == base && n < 400) begin @(negedge clk); n++; end
      check("done_a_seen", ndone_a - base, 1);
   endtask

   task automatic fill_a(input logic signed [15:0] v);
      for (int i = 0; i < 1024; i++) mem_a[i] = v;
   endtask

   int bw, bd;

   initial begin
      reset_n = 1'b0;
      ifa.start = 1'b0; ifa.mode_avg = 1'b0; ifa.relu_en = 1'b0;
      ifb.start = 1'b0; ifb.mode_avg = 1'b0; ifb.relu_en = 1'b0;
      fill_a(16'sd0);
      for (int i = 0; i < 1024; i++) mem_b[i] = 16'sd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_busy", ifa.busy, 0);
      check("rst_done", ifa.done, 0);
      check("rst_rd_en", ifa.in_map_rd_en, 0);
      check("rst_in_addr", ifa.in_map_addr, 0);
      check("rst_we", ifa.out_map_write_en, 0);
      check("rst_out_addr", ifa.out_map_addr, 0);
      check("rst_out_pixel", ifa.out_map_pixel, 0);
      check("rst_busy_b", ifb.busy, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Max pool over a ramp; options flipped and a stray start during the run
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
      bw = nwr_a; bd = ndone_a;
      start_a(1'b0, 1'b0);
      check("busy_after_start", ifa.busy, 1);
      ifa.mode_avg = 1'b1; ifa.relu_en = 1'b1;
      repeat (3) @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      wait_a(bd);
      check("max_out0", out_a[0], 5);
      check("max_out1", out_a[1], 7);
      check("max_out2", out_a[2], 13);
      check("max_out3", out_a[3], 15);
      for (int i = 0; i < 4; i++) check("wr_cycle", wr_rel_a[(bw + i) % 64], 6 * (i + 1));
      check("done_cycle", done_rel_a, 25);
      check("max_nwrites", nwr_a - bw, 4);
      check("busy_after_done", ifa.busy, 0);
      repeat (10) @(negedge clk);
      check("no_restart", nwr_a - bw, 4);

      // Average pool, negative window floors toward -inf
      fill_a(16'sd0);
      mem_a[0] = -16'sd1; mem_a[1] = -16'sd2; mem_a[4] = -16'sd3; mem_a[5] = -16'sd4;
      bd = ndone_a;
      start_a(1'b1, 1'b0);
      wait_a(bd);
      check("avg_out0", out_a[0], -3);
      check("avg_out1", out_a[1], 0);
      check("avg_out3", out_a[3], 0);

      // ReLU on and off over an all -7 map
      fill_a(-16'sd7);
      bd = ndone_a;
      start_a(1'b0, 1'b1);
      wait_a(bd);
      check("relu_on_out0", out_a[0], 0);
      check("relu_on_out3", out_a[3], 0);
      bd = ndone_a;
      start_a(1'b0, 1'b0);
      wait_a(bd);
      check("relu_off_out0", out_a[0], -7);

      // Average extremes
      fill_a(16'sd32767);
      bd = ndone_a;
      start_a(1'b1, 1'b0);
      wait_a(bd);
      check("avg_max_ext", out_a[2], 32767);
      fill_a(-16'sd32768);
      bd = ndone_a;
      start_a(1'b1, 1'b0);
      wait_a(bd);
      check("avg_min_ext", out_a[1], -32768);

      // Reset in the middle of a run
      for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
      bw = nwr_a;
      start_a(1'b0, 1'b0);
      for (int n = 0; n < 100 && (nwr_a - bw) < 2; n++) @(negedge clk);
      check("mid_writes", nwr_a - bw, 2);
      reset_n = 1'b0;
      #1;
      check("abort_busy", ifa.busy, 0);
      check("abort_we", ifa.out_map_write_en, 0);
      check("abort_rd_en", ifa.in_map_rd_en, 0);
      check("abort_pixel", ifa.out_map_pixel, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      check("abort_no_writes", nwr_a - bw, 2);
      bw = nwr_a; bd = ndone_a;
      start_a(1'b0, 1'b0);
      wait_a(bd);
      check("restart_writes", nwr_a - bw, 4);
      check("restart_out3", out_a[3], 15);
      check("no_back_to_back_we", dbl_a, 0);

      // Odd 5x5 geometry, two channels
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 5; r++)
            for (int q = 0; q < 5; q++) mem_b[c * 25 + r * 5 + q] = 16'(r * 5 + q + 100 * c);
      bw = nwr_b; bd = ndone_b;
      @(negedge clk);
      ifb.start = 1'b1; ifb.mode_avg = 1'b0; ifb.relu_en = 1'b0;
      @(negedge clk);
      ifb.start = 1'b0;
      for (int n = 0; n < 400 && ndone_b == bd; n++) @(negedge clk);
      check("done_b_seen", ndone_b - bd, 1);
      check("b_nwrites", nwr_b - bw, 8);
      check("b_done_cycle", done_rel_b, 49);
      check("b_bad_reads", bad_b, 0);
      check("b_out0", out_b[0], 6);
      check("b_out1", out_b[1], 8);
      check("b_out2", out_b[2], 16);
      check("b_out3", out_b[3], 18);
      for (int i = 0; i < 4; i++) check("b_ch1", out_b[4 + i] - out_b[i], 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
